// File: rtl/fib_seq_gen_if.sv
// Command/stream interface for the Fibonacci generator.
// master: the requester/consumer (drives start, n, out_ready).
// slave : the generator (drives the term stream and status).
interface fib_seq_gen_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] n;
  logic [WIDTH-1:0] y;
  logic [IDX_W-1:0] idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, n, out_ready,
    input  y, idx, out_valid, busy, done, overflow
  );

  modport slave (
    input  start, n, out_ready,
    output y, idx, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci sequence generator: on start, emits n terms (INIT_B, INIT_A+INIT_B, ...)
// over a valid/ready stream, modulo 2^WIDTH, with sticky overflow and a done pulse.
// Optional build macro FIB_OVF_STOP_EN: a transfer whose following sum would carry
// ends the run, so a wrapped value is never presented.
module fib_seq_gen #(
  parameter int               WIDTH  = 16,
  parameter int               IDX_W  = 8,
  parameter logic [WIDTH-1:0] INIT_A = '0,
  parameter logic [WIDTH-1:0] INIT_B = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic           clk,
  input  logic           rst,
  fib_seq_gen_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] y_q, prev_q;
  logic [IDX_W-1:0] idx_q, cnt_q;
  logic             vld_q, busy_q, done_q, ovf_q;

  logic [WIDTH:0]   sum;
  logic             carry, xfer, last;

  // Next-term sum, transfer strobe and end-of-run decision
  always_comb begin
    sum   = {1'b0, y_q} + {1'b0, prev_q};
    carry = sum[WIDTH];
    xfer  = vld_q && bus.out_ready;
`ifdef FIB_OVF_STOP_EN
    last  = (idx_q == cnt_q - IDX_W'(1)) || carry;
`else
    last  = (idx_q == cnt_q - IDX_W'(1));
`endif
  end

  // Run control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      y_q    <= '0;
      prev_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ovf_q <= 1'b0;
            if (bus.n != '0) begin
              state  <= RUN;
              y_q    <= INIT_B;
              prev_q <= INIT_A;
              idx_q  <= '0;
              cnt_q  <= bus.n;
              vld_q  <= 1'b1;
              busy_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (last) begin
              // y/idx keep the final term's values after the run
              state  <= IDLE;
              vld_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
`ifdef FIB_OVF_STOP_EN
              if (carry) ovf_q <= 1'b1;
`endif
            end else begin
              y_q    <= sum[WIDTH-1:0];
              prev_q <= y_q;
              idx_q  <= idx_q + IDX_W'(1);
              if (carry) ovf_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y         = y_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;

endmodule
